jpcc_cycle_sequencer: RTL and testbench
=======================================

Name: jpcc_cycle_sequencer

Overview:
- Multi-cycle controller for the conditional absolute jump (JP cc,nn) once the instruction decoder has identified it.
- Latches the condition code and flags, then sequences two operand-byte reads through the PC-addressed memory port with a ready handshake. It then either loads PC from the operand latches (taken) or leaves it pointing past the operand (not taken).
- Sits between the instruction decoder/phase logic and the PC / operand-latch datapath. Includes a wait-state watchdog and a synchronous flush.

Parameters:
- MAX_WAIT, 15, maximum consecutive cycles without mem_ready in a fetch state before bus_error.
- WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- CLK  input  1  single clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- start  input  1  decoder strobe: JP cc,nn decoded; sampled only in IDLE.
- cc  input  3  condition field. cc[2:1] selects the flag: 00 Z, 01 C, 10 PV, 11 S. cc[0] is the required flag value: 0 means the flag must be 0, 1 means it must be 1.
- Flag_Z, Flag_C, Flag_PV, Flag_S  input  1 each  current flags.
- flush  input  1  synchronous abort.
- mem_ready  input  1  memory read data valid this cycle.
- mem_req  output  1  read request at PC.
- op_low_load  output  1  capture read data into operand-low latch.
- op_high_load  output  1  capture read data into operand-high latch.
- pc_inc  output  1  increment PC.
- pc_load  output  1  PC <= {operand high, operand low}.
- taken  output  1  latched condition result, valid while busy.
- busy  output  1  sequencer not in IDLE.
- done  output  1  one-cycle completion pulse.
- bus_error  output  1  one-cycle watchdog pulse.

Behaviour:
- States: IDLE, FETCH_LO, FETCH_HI, LOAD_PC, FINISH.
- Reset: state is IDLE; the latched cc, latched flag and wait counter are 0; every output is 0. Reset in any state forces this immediately, and no pulse is emitted.
- IDLE: busy=0.
  - On start=1 and flush=0: latch taken = (selected flag == cc[0]); clear the wait counter; go to FETCH_LO.
  - Flags and cc are sampled only on this edge; later changes are ignored.
- FETCH_LO: mem_req=1.
  - If mem_ready=1: op_low_load=1 and pc_inc=1 combinationally in the same cycle; clear the wait counter; go to FETCH_HI.
  - Otherwise increment the wait counter.
- FETCH_HI: same handshake, but asserting op_high_load=1 and pc_inc=1.
  - On ready, go to LOAD_PC if taken=1, otherwise go to FINISH.
- LOAD_PC: pc_load=1 for exactly one cycle; go to FINISH.
- FINISH: done=1 for one cycle; go to IDLE. A start in FINISH is ignored; start is accepted no earlier than the following IDLE cycle.
- Both operand bytes are always read, whatever the condition. PC therefore always advances by 2 before any pc_load.
- Watchdog: in a fetch state, if mem_ready=0 and the wait counter equals MAX_WAIT, assert bus_error=1 for one cycle. Go to IDLE with no done and no load pulses. The counter never wraps.
- Flush: flush=1 in any non-IDLE state sends the sequencer to IDLE on the next edge.
  - Flush takes priority over mem_ready, the watchdog and done.
  - While flush=1, mem_req, the load pulses, pc_inc, pc_load, done and bus_error are all forced to 0.
  - Flush in IDLE blocks start.
- Latency with mem_ready held high (start accepted at edge 0): op_low_load in cycle 1, op_high_load in cycle 2.
  - Taken: pc_load in cycle 3, done in cycle 4.
  - Not taken: done in cycle 3.
- Only one of op_low_load, op_high_load, pc_load is ever high at a time. pc_inc is never high together with pc_load.

Decomposition:
- Shared package holds:
  - the state encoding constants;
  - the cc selector constants (CC_Z=2'b00, CC_C=2'b01, CC_PV=2'b10, CC_S=2'b11).
  - The package is reused by the CALL cc and RET cc sequencers.
- One sub-module, jpcc_cond_eval: combinational 4:1 flag mux followed by a polarity XNOR with cc[0], producing taken_next. Everything else lives in the top FSM.

Test Plan:
- Taken Z: Flag_Z=1, cc=3'b001, start, mem_ready=1 -> op_low_load c1, op_high_load c2, pc_load c3, done c4, taken=1, pc_inc pulses=2.
- Not taken C: Flag_C=1, cc=3'b010 -> no pc_load, done c3, taken=0. Toggling Flag_C after start has no effect.
- Wait states: cc=3'b111, Flag_S=1, mem_ready low 3 cycles in FETCH_LO and 2 in FETCH_HI -> mem_req held throughout, single load pulse per byte, done 4+5=9 cycles after start, no bus_error.
- Watchdog: MAX_WAIT=15, mem_ready=0 forever after start -> bus_error single pulse in the 16th FETCH_LO cycle, then IDLE, busy=0, no done.
- Flush collision: assert flush and mem_ready together in FETCH_HI -> no op_high_load, no pc_inc, no done; IDLE next cycle; a new start then runs a clean sequence.
- Async reset in LOAD_PC -> all outputs 0 immediately, no pc_load or done; start held during FINISH is ignored.

Source files
------------

// File: rtl/jpcc_cycle_sequencer_pkg.sv
// Shared definitions for the conditional-flow sequencers (JP cc, CALL cc, RET cc):
// sequencer state encoding and condition-field flag selectors.
package jpcc_cycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_LO = 3'd1,
        ST_FETCH_HI = 3'd2,
        ST_LOAD_PC  = 3'd3,
        ST_FINISH   = 3'd4
    } seq_state_e;

    // cc[2:1] selects which flag the condition tests
    localparam logic [1:0] CC_Z  = 2'b00;
    localparam logic [1:0] CC_C  = 2'b01;
    localparam logic [1:0] CC_PV = 2'b10;
    localparam logic [1:0] CC_S  = 2'b11;

    function automatic logic is_fetch(seq_state_e s);
        return (s == ST_FETCH_LO) || (s == ST_FETCH_HI);
    endfunction

endpackage

// File: rtl/jpcc_cycle_sequencer_if.sv
// Decoder / memory-port / PC-datapath signal bundle around the JP cc,nn sequencer.
interface jpcc_cycle_sequencer_if;
    logic       start;
    logic [2:0] cc;
    logic       Flag_Z;
    logic       Flag_C;
    logic       Flag_PV;
    logic       Flag_S;
    logic       flush;
    logic       mem_ready;
    logic       mem_req;
    logic       op_low_load;
    logic       op_high_load;
    logic       pc_inc;
    logic       pc_load;
    logic       taken;
    logic       busy;
    logic       done;
    logic       bus_error;

    modport master (
        output start, cc, Flag_Z, Flag_C, Flag_PV, Flag_S, flush, mem_ready,
        input  mem_req, op_low_load, op_high_load, pc_inc, pc_load,
               taken, busy, done, bus_error
    );

    modport slave (
        input  start, cc, Flag_Z, Flag_C, Flag_PV, Flag_S, flush, mem_ready,
        output mem_req, op_low_load, op_high_load, pc_inc, pc_load,
               taken, busy, done, bus_error
    );
endinterface

// File: rtl/jpcc_cond_eval.sv
// Condition evaluator: picks the flag named by cc[2:1] and compares it with the
// polarity bit cc[0].
module jpcc_cond_eval
    import jpcc_cycle_sequencer_pkg::*;
(
    input  logic [2:0] cc_i,
    input  logic       flag_z_i,
    input  logic       flag_c_i,
    input  logic       flag_pv_i,
    input  logic       flag_s_i,
    output logic       taken_next_o
);

    logic flag_sel;

    always_comb begin
        flag_sel = flag_z_i;
        case (cc_i[2:1])
            CC_Z:    flag_sel = flag_z_i;
            CC_C:    flag_sel = flag_c_i;
            CC_PV:   flag_sel = flag_pv_i;
            CC_S:    flag_sel = flag_s_i;
            default: flag_sel = flag_z_i;
        endcase
        taken_next_o = ~(flag_sel ^ cc_i[0]);
    end

endmodule

// File: rtl/jpcc_cycle_sequencer.sv
// JP cc,nn sequencer: reads both operand bytes through the PC-addressed port,
// then loads PC when the latched condition holds. Includes wait watchdog and flush.
module jpcc_cycle_sequencer
    import jpcc_cycle_sequencer_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    jpcc_cycle_sequencer_if.slave   bus
);

    seq_state_e        state_q, state_d;
    logic              taken_q, taken_d;
    logic [WAIT_W-1:0] wait_q,  wait_d;
    logic              taken_next;
    logic              wait_hit;

    jpcc_cond_eval u_cond_eval (
        .cc_i         (bus.cc),
        .flag_z_i     (bus.Flag_Z),
        .flag_c_i     (bus.Flag_C),
        .flag_pv_i    (bus.Flag_PV),
        .flag_s_i     (bus.Flag_S),
        .taken_next_o (taken_next)
    );

    assign wait_hit = (wait_q == WAIT_W'(MAX_WAIT));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            taken_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        wait_d  = wait_q;
        // Flush outranks every other transition once a sequence is in flight
        if (state_q != ST_IDLE && bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        taken_d = taken_next;
                        wait_d  = '0;
                        state_d = ST_FETCH_LO;
                    end
                end
                ST_FETCH_LO, ST_FETCH_HI: begin
                    if (bus.mem_ready) begin
                        wait_d = '0;
                        if (state_q == ST_FETCH_LO) state_d = ST_FETCH_HI;
                        else                        state_d = taken_q ? ST_LOAD_PC : ST_FINISH;
                    end else if (wait_hit) begin
                        state_d = ST_IDLE;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                ST_LOAD_PC: state_d = ST_FINISH;
                ST_FINISH:  state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_req      = 1'b0;
        bus.op_low_load  = 1'b0;
        bus.op_high_load = 1'b0;
        bus.pc_inc       = 1'b0;
        bus.pc_load      = 1'b0;
        bus.done         = 1'b0;
        bus.bus_error    = 1'b0;
        bus.busy         = (state_q != ST_IDLE);
        bus.taken        = (state_q != ST_IDLE) && taken_q;
        if (!bus.flush) begin
            if (is_fetch(state_q)) begin
                bus.mem_req      = 1'b1;
                bus.op_low_load  = (state_q == ST_FETCH_LO) && bus.mem_ready;
                bus.op_high_load = (state_q == ST_FETCH_HI) && bus.mem_ready;
                bus.pc_inc       = bus.mem_ready;
                bus.bus_error    = !bus.mem_ready && wait_hit;
            end
            bus.pc_load = (state_q == ST_LOAD_PC);
            bus.done    = (state_q == ST_FINISH);
        end
    end

endmodule

// File: tb/tb_jpcc_cycle_sequencer.sv
// Bench for jpcc_cycle_sequencer: vector table, directed corner sequences and
// randomized transactions compared cycle by cycle against an expected-trace model.
module tb_jpcc_cycle_sequencer;

    localparam int MAXW = 15;

    // Packed output view: {mem_req, op_low, op_high, pc_inc, pc_load, done, bus_error, busy, taken}
    localparam logic [8:0] O_REQ   = 9'h100;
    localparam logic [8:0] O_LO    = 9'h080;
    localparam logic [8:0] O_HI    = 9'h040;
    localparam logic [8:0] O_INC   = 9'h020;
    localparam logic [8:0] O_LD    = 9'h010;
    localparam logic [8:0] O_DONE  = 9'h008;
    localparam logic [8:0] O_BERR  = 9'h004;
    localparam logic [8:0] O_BUSY  = 9'h002;
    localparam logic [8:0] O_TAKEN = 9'h001;

    typedef struct {
        logic       rdy;
        logic [8:0] exp;
        logic       st;
    } step_t;

    typedef struct {
        logic [2:0] cc;
        logic [3:0] fl;   // {S, PV, C, Z}
        bit         tk;
        int         wlo;
        int         whi;
    } vec_t;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;
    step_t q[$];
    vec_t  tbl[8];

    jpcc_cycle_sequencer_if bus ();

    jpcc_cycle_sequencer #(.MAX_WAIT(MAXW), .WAIT_W(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [8:0] outs();
        return {bus.mem_req, bus.op_low_load, bus.op_high_load, bus.pc_inc,
                bus.pc_load, bus.done, bus.bus_error, bus.busy, bus.taken};
    endfunction

    function automatic bit model_taken(logic [2:0] cc, logic [3:0] fl);
        int sel;
        sel = int'(cc[2:1]);
        return fl[sel] == cc[0];
    endfunction

    task automatic chk(string nm, logic [8:0] act, logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Expected per-cycle trace of one transaction, given wait cycles per operand byte
    task automatic build(int wlo, int whi, bit tk, bit start_fin);
        logic [8:0] base;
        int waits[2];
        waits[0] = wlo;
        waits[1] = whi;
        base = O_BUSY | (tk ? O_TAKEN : 9'h000);
        q.delete();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < waits[b]; i++) begin
                if (i == MAXW) begin
                    q.push_back('{1'b0, base | O_REQ | O_BERR, 1'b0});
                    return;
                end
                q.push_back('{1'b0, base | O_REQ, 1'b0});
            end
            q.push_back('{1'b1, base | O_REQ | O_INC | ((b == 0) ? O_LO : O_HI), 1'b0});
        end
        if (tk) q.push_back('{1'($urandom), base | O_LD, 1'b0});
        q.push_back('{1'($urandom), base | O_DONE, start_fin});
    endtask

    task automatic run(string nm, logic [2:0] cc, logic [3:0] fl, bit tk,
                       int wlo, int whi, bit start_fin);
        @(negedge CLK);
        bus.start = 1'b1;
        bus.cc    = cc;
        {bus.Flag_S, bus.Flag_PV, bus.Flag_C, bus.Flag_Z} = fl;
        bus.mem_ready = 1'($urandom);
        bus.flush = 1'b0;
        #1 chk($sformatf("%s_idle", nm), outs(), 9'h000);
        build(wlo, whi, tk, start_fin);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge CLK);
            bus.start     = q[k].st;
            bus.mem_ready = q[k].rdy;
            bus.cc        = 3'($urandom);
            {bus.Flag_S, bus.Flag_PV, bus.Flag_C, bus.Flag_Z} = 4'($urandom);
            #1 chk($sformatf("%s_c%0d", nm, k + 1), outs(), q[k].exp);
        end
        @(negedge CLK);
        bus.start     = 1'b0;
        bus.mem_ready = 1'($urandom);
        #1 chk($sformatf("%s_end", nm), outs(), 9'h000);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tbl[0] = '{3'b001, 4'b0001, 1'b1, 0, 0};
        tbl[1] = '{3'b000, 4'b0001, 1'b0, 0, 0};
        tbl[2] = '{3'b010, 4'b0010, 1'b0, 0, 0};
        tbl[3] = '{3'b011, 4'b0010, 1'b1, 0, 0};
        tbl[4] = '{3'b100, 4'b0000, 1'b1, 0, 0};
        tbl[5] = '{3'b101, 4'b0100, 1'b1, 1, 0};
        tbl[6] = '{3'b111, 4'b1000, 1'b1, 3, 2};
        tbl[7] = '{3'b110, 4'b1000, 1'b0, 1, 1};

        RESET = 1'b1;
        bus.start = 1'b0;
        bus.cc = 3'b000;
        {bus.Flag_S, bus.Flag_PV, bus.Flag_C, bus.Flag_Z} = 4'b0000;
        bus.flush = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (3) @(negedge CLK);
        bus.start = 1'b1;
        #1 chk("reset_state", outs(), 9'h000);
        bus.start = 1'b0;
        RESET = 1'b0;

        for (int v = 0; v < 8; v++)
            run($sformatf("vec%0d", v), tbl[v].cc, tbl[v].fl, tbl[v].tk,
                tbl[v].wlo, tbl[v].whi, 1'b0);

        // Watchdog: ready never arrives in FETCH_LO
        run("watchdog", 3'b111, 4'b1000, 1'b1, 16, 0, 1'b0);
        run("after_wd", 3'b010, 4'b0000, 1'b1, 0, 0, 1'b0);

        // Start held high through FINISH must not begin a new sequence
        run("start_fin", 3'b001, 4'b0001, 1'b1, 0, 0, 1'b1);

        // Flush colliding with ready in FETCH_HI
        @(negedge CLK);
        bus.start = 1'b1; bus.cc = 3'b001;
        {bus.Flag_S, bus.Flag_PV, bus.Flag_C, bus.Flag_Z} = 4'b0001;
        bus.mem_ready = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        #1 chk("fl_lo", outs(), O_REQ | O_LO | O_INC | O_BUSY | O_TAKEN);
        @(negedge CLK);
        bus.flush = 1'b1;
        #1 chk("fl_hi", outs(), O_BUSY | O_TAKEN);
        @(negedge CLK);
        bus.flush = 1'b0;
        #1 chk("fl_idle", outs(), 9'h000);
        run("fl_clean", 3'b011, 4'b0010, 1'b1, 0, 1, 1'b0);

        // Flush in IDLE blocks start
        @(negedge CLK);
        bus.start = 1'b1; bus.flush = 1'b1;
        #1 chk("fl_block0", outs(), 9'h000);
        @(negedge CLK);
        bus.start = 1'b0; bus.flush = 1'b0;
        #1 chk("fl_block1", outs(), 9'h000);

        // Asynchronous reset while in LOAD_PC
        @(negedge CLK);
        bus.start = 1'b1; bus.cc = 3'b001;
        {bus.Flag_S, bus.Flag_PV, bus.Flag_C, bus.Flag_Z} = 4'b0001;
        bus.mem_ready = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #1 chk("rst_ldpc", outs(), O_LD | O_BUSY | O_TAKEN);
        RESET = 1'b1;
        #1 chk("rst_async", outs(), 9'h000);
        @(negedge CLK);
        #1 chk("rst_hold", outs(), 9'h000);
        RESET = 1'b0;
        @(negedge CLK);
        #1 chk("rst_after", outs(), 9'h000);

        // Randomized transactions against the trace model
        for (int t = 0; t < 40; t++) begin
            logic [2:0] rcc;
            logic [3:0] rfl;
            int wl, wh;
            rcc = 3'($urandom);
            rfl = 4'($urandom);
            wl = ($urandom_range(0, 9) == 0) ? 16 : int'($urandom_range(0, 4));
            wh = ($urandom_range(0, 9) == 0) ? 16 : int'($urandom_range(0, 4));
            run($sformatf("rnd%0d", t), rcc, rfl, model_taken(rcc, rfl), wl, wh,
                1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
